// File: rtl/sprite_pkg.sv
// Shared constants for the sprite overlay: palette, default screen size and
// the saturating position step used for per-frame movement.
package sprite_pkg;

  localparam int SCREEN_W_DEF = 800;
  localparam int SCREEN_H_DEF = 600;

  localparam logic [23:0] PALETTE [8] = '{
    24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFF00,
    24'hFF00FF, 24'h00FFFF, 24'hFFFFFF, 24'hFF8000
  };

  // Evaluated at 17 bits so neither direction can wrap.
  function automatic logic [15:0] sat_step(input logic [15:0] pos,
                                           input logic [15:0] step,
                                           input logic [15:0] max_v,
                                           input logic        inc);
    logic [16:0] sum;
    sum = {1'b0, pos} + {1'b0, step};
    if (inc)
      return (sum > {1'b0, max_v}) ? max_v : sum[15:0];
    else
      return ({1'b0, pos} < {1'b0, step}) ? '0 : pos - step;
  endfunction

endpackage

// File: rtl/sprite_engine_if.sv
// Pixel, control and overlay-result bundle between the raster source and the
// sprite engine. Master drives raster/buttons, slave returns overlay data.
interface sprite_engine_if #(
  parameter int N_SPRITES = 4,
  parameter int SEL_W     = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1
);
  logic [15:0]             i_x;
  logic [15:0]             i_y;
  logic                    i_v_sync;
  logic [SEL_W-1:0]        i_sel;
  logic                    i_btn_x;
  logic                    i_btn_y;
  logic                    i_dir;
  logic [7:0]              o_red;
  logic [7:0]              o_green;
  logic [7:0]              o_blue;
  logic                    o_sprite_hit;
  logic [SEL_W-1:0]        o_sprite_id;
  logic [N_SPRITES*16-1:0] o_pos_x;
  logic [N_SPRITES*16-1:0] o_pos_y;

  modport master (
    output i_x, i_y, i_v_sync, i_sel, i_btn_x, i_btn_y, i_dir,
    input  o_red, o_green, o_blue, o_sprite_hit, o_sprite_id, o_pos_x, o_pos_y
  );

  modport slave (
    input  i_x, i_y, i_v_sync, i_sel, i_btn_x, i_btn_y, i_dir,
    output o_red, o_green, o_blue, o_sprite_hit, o_sprite_id, o_pos_x, o_pos_y
  );
endinterface

// File: rtl/sprite_mask_rom.sv
// Combinational 1-bit shape lookup per (id, local y, local x); each sprite is
// a ring with a solid 1-pixel border and transparent interior.
module sprite_mask_rom #(
  parameter int N_SPRITES = 4,
  parameter int SPRITE_W  = 16,
  parameter int SPRITE_H  = 16,
  parameter int SEL_W     = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1,
  parameter int LXW       = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1,
  parameter int LYW       = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1
) (
  input  logic [SEL_W-1:0] id,
  input  logic [LXW-1:0]   lx,
  input  logic [LYW-1:0]   ly,
  output logic             mask
);
  localparam int IW = ($clog2(SPRITE_W*SPRITE_H) > 0) ? $clog2(SPRITE_W*SPRITE_H) : 1;

  function automatic logic [SPRITE_W*SPRITE_H-1:0] ring_mask();
    logic [SPRITE_W*SPRITE_H-1:0] m;
    m = '0;
    for (int unsigned y = 0; y < SPRITE_H; y++)
      for (int unsigned x = 0; x < SPRITE_W; x++)
        m[y*SPRITE_W + x] = (x == 0) || (x == SPRITE_W-1) || (y == 0) || (y == SPRITE_H-1);
    return m;
  endfunction

  localparam logic [SPRITE_W*SPRITE_H-1:0] RING = ring_mask();

  logic [IW-1:0] idx;

  always_comb begin
    idx  = IW'(32'(ly) * SPRITE_W + 32'(lx));
    mask = 1'b0;
    if (32'(id) < N_SPRITES && 32'(lx) < SPRITE_W && 32'(ly) < SPRITE_H)
      mask = RING[idx];
  end
endmodule

// File: rtl/sprite_engine.sv
// N-sprite overlay with per-frame saturating movement and fixed-priority
// compositing; 2-clk pixel path. Define SPRITE_BITMAP_EN for ring-shaped masks.
module sprite_engine
  import sprite_pkg::*;
#(
  parameter int N_SPRITES = 4,
  parameter int SPRITE_W  = 16,
  parameter int SPRITE_H  = 16,
  parameter int SCREEN_W  = SCREEN_W_DEF,
  parameter int SCREEN_H  = SCREEN_H_DEF,
  parameter int STEP      = 1,
  parameter int SEL_W     = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1
) (
  input  logic           clk,
  input  logic           rst,
  sprite_engine_if.slave bus
);
  localparam logic [15:0] MAX_X  = 16'(SCREEN_W - SPRITE_W);
  localparam logic [15:0] MAX_Y  = 16'(SCREEN_H - SPRITE_H);
  localparam logic [15:0] STEP16 = 16'(STEP);

  logic        vs_d;
  logic        armed;
  logic        tick;
  logic [15:0] pos_x [N_SPRITES];
  logic [15:0] pos_y [N_SPRITES];

  // armed blocks a v_sync level still high when reset drops from counting as an edge.
  assign tick = bus.i_v_sync & ~vs_d & armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_d  <= 1'b0;
      armed <= 1'b0;
      for (int unsigned i = 0; i < N_SPRITES; i++) begin
        pos_x[i] <= 16'(i * 2 * SPRITE_W);
        pos_y[i] <= '0;
      end
    end else begin
      vs_d  <= bus.i_v_sync;
      armed <= armed | ~bus.i_v_sync;
      for (int unsigned i = 0; i < N_SPRITES; i++) begin
        if (tick && 32'(bus.i_sel) == i) begin
          if (bus.i_btn_x) pos_x[i] <= sat_step(pos_x[i], STEP16, MAX_X, bus.i_dir);
          if (bus.i_btn_y) pos_y[i] <= sat_step(pos_y[i], STEP16, MAX_Y, bus.i_dir);
        end
      end
    end
  end

  logic [N_SPRITES*16-1:0] pos_x_flat;
  logic [N_SPRITES*16-1:0] pos_y_flat;

  always_comb begin
    pos_x_flat = '0;
    pos_y_flat = '0;
    for (int unsigned i = 0; i < N_SPRITES; i++) begin
      pos_x_flat[16*i +: 16] = pos_x[i];
      pos_y_flat[16*i +: 16] = pos_y[i];
    end
  end

  assign bus.o_pos_x = pos_x_flat;
  assign bus.o_pos_y = pos_y_flat;

  // Stage 1: per-sprite rectangle hit (optionally masked by shape).
  logic [N_SPRITES-1:0] hit_c;
  logic [N_SPRITES-1:0] s1_hit;

  always_comb begin
    hit_c = '0;
    for (int unsigned i = 0; i < N_SPRITES; i++) begin
      hit_c[i] = ({1'b0, bus.i_x} >= {1'b0, pos_x[i]}) &&
                 ({1'b0, bus.i_x} <  ({1'b0, pos_x[i]} + 17'(SPRITE_W))) &&
                 ({1'b0, bus.i_y} >= {1'b0, pos_y[i]}) &&
                 ({1'b0, bus.i_y} <  ({1'b0, pos_y[i]} + 17'(SPRITE_H)));
    end
  end

`ifdef SPRITE_BITMAP_EN
  localparam int LXW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int LYW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

  logic [LXW-1:0]       lx [N_SPRITES];
  logic [LYW-1:0]       ly [N_SPRITES];
  logic [N_SPRITES-1:0] mask_c;

  always_comb begin
    for (int unsigned i = 0; i < N_SPRITES; i++) begin
      lx[i] = LXW'(bus.i_x - pos_x[i]);
      ly[i] = LYW'(bus.i_y - pos_y[i]);
    end
  end

  for (genvar g = 0; g < N_SPRITES; g++) begin : g_rom
    sprite_mask_rom #(
      .N_SPRITES (N_SPRITES),
      .SPRITE_W  (SPRITE_W),
      .SPRITE_H  (SPRITE_H),
      .SEL_W     (SEL_W),
      .LXW       (LXW),
      .LYW       (LYW)
    ) u_rom (
      .id   (SEL_W'(g)),
      .lx   (lx[g]),
      .ly   (ly[g]),
      .mask (mask_c[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) s1_hit <= '0;
    else     s1_hit <= hit_c & mask_c;
  end
`else
  always_ff @(posedge clk) begin
    if (rst) s1_hit <= '0;
    else     s1_hit <= hit_c;
  end
`endif

  // Stage 2: lowest hitting index wins.
  logic             win_any;
  logic [SEL_W-1:0] win_id;
  logic [2:0]       pal_idx;
  logic             hit_q;
  logic [SEL_W-1:0] id_q;
  logic [23:0]      rgb_q;

  always_comb begin
    win_any = 1'b0;
    win_id  = '0;
    pal_idx = '0;
    for (int unsigned i = 0; i < N_SPRITES; i++) begin
      if (!win_any && s1_hit[i]) begin
        win_any = 1'b1;
        win_id  = SEL_W'(i);
        pal_idx = 3'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q <= 1'b0;
      id_q  <= '0;
      rgb_q <= '0;
    end else begin
      hit_q <= win_any;
      id_q  <= win_id;
      rgb_q <= win_any ? PALETTE[pal_idx] : '0;
    end
  end

  assign bus.o_sprite_hit = hit_q;
  assign bus.o_sprite_id  = id_q;
  assign bus.o_red        = rgb_q[23:16];
  assign bus.o_green      = rgb_q[15:8];
  assign bus.o_blue       = rgb_q[7:0];
endmodule

// File: tb/tb_sprite_engine.sv
// Directed bench for sprite_engine: two instances (STEP=1 / STEP=7 with a
// widened select) covering reset, movement, saturation, priority and latency.
module tb_sprite_engine;
  logic clk = 1'b0;
  logic rst;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  sprite_engine_if #(.N_SPRITES(4), .SEL_W(2)) ifa ();
  sprite_engine_if #(.N_SPRITES(4), .SEL_W(3)) ifb ();

  sprite_engine #(
    .N_SPRITES (4), .SPRITE_W (16), .SPRITE_H (16),
    .SCREEN_W  (800), .SCREEN_H (600), .STEP (1), .SEL_W (2)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  sprite_engine #(
    .N_SPRITES (4), .SPRITE_W (16), .SPRITE_H (16),
    .SCREEN_W  (800), .SCREEN_H (600), .STEP (7), .SEL_W (3)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ax(input int unsigned i);
    return ifa.o_pos_x[16*i +: 16];
  endfunction
  function automatic logic [15:0] ay(input int unsigned i);
    return ifa.o_pos_y[16*i +: 16];
  endfunction
  function automatic logic [15:0] bx(input int unsigned i);
    return ifb.o_pos_x[16*i +: 16];
  endfunction
  function automatic logic [23:0] a_rgb();
    return {ifa.o_red, ifa.o_green, ifa.o_blue};
  endfunction

  task automatic idle_inputs();
    ifa.i_x = '0; ifa.i_y = '0; ifa.i_v_sync = 1'b0; ifa.i_sel = '0;
    ifa.i_btn_x = 1'b0; ifa.i_btn_y = 1'b0; ifa.i_dir = 1'b0;
    ifb.i_x = '0; ifb.i_y = '0; ifb.i_v_sync = 1'b0; ifb.i_sel = '0;
    ifb.i_btn_x = 1'b0; ifb.i_btn_y = 1'b0; ifb.i_dir = 1'b0;
  endtask

  task automatic pulse(input int unsigned n);
    repeat (n) begin
      @(negedge clk);
      ifa.i_v_sync = 1'b1; ifb.i_v_sync = 1'b1;
      @(negedge clk);
      ifa.i_v_sync = 1'b0; ifb.i_v_sync = 1'b0;
    end
  endtask

  task automatic pix(input string tag, input logic [15:0] x, input logic [15:0] y,
                     input logic exp_hit, input logic [1:0] exp_id, input logic [23:0] exp_rgb);
    @(negedge clk);
    ifa.i_x = x; ifa.i_y = y;
    @(negedge clk);
    @(negedge clk);
    check_eq({tag, "_hit"}, 64'(ifa.o_sprite_hit), 64'(exp_hit));
    check_eq({tag, "_id"},  64'(ifa.o_sprite_id),  64'(exp_id));
    check_eq({tag, "_rgb"}, 64'(a_rgb()),          64'(exp_rgb));
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);

    check_eq("rst_x1",  64'(ax(1)), 64'd32);
    check_eq("rst_y1",  64'(ay(1)), 64'd0);
    check_eq("rst_x3",  64'(ax(3)), 64'd96);
    check_eq("rst_bx2", 64'(bx(2)), 64'd64);
    check_eq("rst_hit", 64'(ifa.o_sprite_hit), 64'd0);
    check_eq("rst_id",  64'(ifa.o_sprite_id), 64'd0);
    check_eq("rst_rgb", 64'(a_rgb()), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Five frames right on sprite 0.
    ifa.i_sel = 2'd0; ifa.i_dir = 1'b1; ifa.i_btn_x = 1'b1;
    pulse(5);
    check_eq("mv5_x0", 64'(ax(0)), 64'd5);
    check_eq("mv5_y0", 64'(ay(0)), 64'd0);
    check_eq("mv5_x1", 64'(ax(1)), 64'd32);
    check_eq("mv5_x2", 64'(ax(2)), 64'd64);

    // A long v_sync pulse is still a single move.
    @(negedge clk); ifa.i_v_sync = 1'b1; ifb.i_v_sync = 1'b1;
    repeat (5) @(negedge clk);
    ifa.i_v_sync = 1'b0; ifb.i_v_sync = 1'b0;
    @(negedge clk);
    check_eq("long_x0", 64'(ax(0)), 64'd6);

    ifa.i_btn_y = 1'b1;
    pulse(1);
    check_eq("xy_x0", 64'(ax(0)), 64'd7);
    check_eq("xy_y0", 64'(ay(0)), 64'd1);

    // Slide sprite 1 left under sprite 0: sprite0 at (7,1), sprite1 at (5,0).
    ifa.i_sel = 2'd1; ifa.i_dir = 1'b0; ifa.i_btn_y = 1'b0;
    pulse(27);
    check_eq("ovl_x1", 64'(ax(1)), 64'd5);
    check_eq("ovl_y1", 64'(ay(1)), 64'd0);
    check_eq("ovl_x0", 64'(ax(0)), 64'd7);
    ifa.i_btn_x = 1'b0;

    // Exact 2-clk latency.
    @(negedge clk); ifa.i_x = 16'd300; ifa.i_y = 16'd300;
    repeat (2) @(negedge clk);
    ifa.i_x = 16'd7; ifa.i_y = 16'd1;
    @(negedge clk);
    check_eq("lat1_hit", 64'(ifa.o_sprite_hit), 64'd0);
    @(negedge clk);
    check_eq("lat2_hit", 64'(ifa.o_sprite_hit), 64'd1);
    check_eq("lat2_id",  64'(ifa.o_sprite_id), 64'd0);
    check_eq("lat2_rgb", 64'(a_rgb()), 64'hFF0000);

`ifdef SPRITE_BITMAP_EN
    pix("ovl_in", 16'd20, 16'd5, 1'b1, 2'd1, 24'h00FF00);
`else
    pix("ovl_in", 16'd20, 16'd5, 1'b1, 2'd0, 24'hFF0000);
`endif
    pix("s1_only",    16'd5,   16'd0,  1'b1, 2'd1, 24'h00FF00);
    pix("s0_edge",    16'd22,  16'd16, 1'b1, 2'd0, 24'hFF0000);
    pix("miss_right", 16'd23,  16'd5,  1'b0, 2'd0, 24'h000000);
    pix("s3_corner",  16'd111, 16'd15, 1'b1, 2'd3, 24'hFFFF00);
    pix("miss_below", 16'd100, 16'd16, 1'b0, 2'd0, 24'h000000);

    // Reset during a held v_sync with a button down.
    ifa.i_sel = 2'd0; ifa.i_dir = 1'b1; ifa.i_btn_x = 1'b1;
    @(negedge clk); ifa.i_v_sync = 1'b1; ifb.i_v_sync = 1'b1;
    @(negedge clk);
    check_eq("pre_rst_x0", 64'(ax(0)), 64'd8);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_x0", 64'(ax(0)), 64'd0);
    check_eq("mid_rst_x1", 64'(ax(1)), 64'd32);
    check_eq("mid_rst_hit", 64'(ifa.o_sprite_hit), 64'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    ifa.i_v_sync = 1'b0; ifb.i_v_sync = 1'b0;
    @(negedge clk);
    check_eq("post_rst_x0", 64'(ax(0)), 64'd0);
    pulse(1);
    check_eq("rearm_x0", 64'(ax(0)), 64'd1);
    idle_inputs();

    // STEP=7 instance: saturation at both ends.
    ifb.i_sel = 3'd2; ifb.i_dir = 1'b1; ifb.i_btn_x = 1'b1;
    pulse(102);
    check_eq("b_x2_778", 64'(bx(2)), 64'd778);
    pulse(1);
    check_eq("b_x2_max", 64'(bx(2)), 64'd784);
    pulse(1);
    check_eq("b_x2_hold", 64'(bx(2)), 64'd784);
    check_eq("b_x1_keep", 64'(bx(1)), 64'd32);

    ifb.i_sel = 3'd1; ifb.i_dir = 1'b0;
    pulse(4);
    check_eq("b_x1_4", 64'(bx(1)), 64'd4);
    pulse(1);
    check_eq("b_x1_floor", 64'(bx(1)), 64'd0);
    pulse(1);
    check_eq("b_x1_hold", 64'(bx(1)), 64'd0);

    ifb.i_sel = 3'd5; ifb.i_dir = 1'b1; ifb.i_btn_x = 1'b1; ifb.i_btn_y = 1'b1;
    pulse(2);
    check_eq("b_sel5_x", 64'(ifb.o_pos_x), {16'd96, 16'd784, 16'd0, 16'd0});
    check_eq("b_sel5_y", 64'(ifb.o_pos_y), 64'd0);
    ifb.i_btn_x = 1'b0; ifb.i_btn_y = 1'b0;

    // Right screen edge pixel of sprite 2.
    @(negedge clk); ifb.i_x = 16'd799; ifb.i_y = 16'd15;
    repeat (2) @(negedge clk);
    check_eq("b_edge_hit", 64'(ifb.o_sprite_hit), 64'd1);
    check_eq("b_edge_id",  64'(ifb.o_sprite_id), 64'd2);
    check_eq("b_edge_rgb", 64'({ifb.o_red, ifb.o_green, ifb.o_blue}), 64'h0000FF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
